// File: rtl/rle_decoder_if.sv
// Byte-stream handshake bundle for the RLE decoder: (count,symbol) input side
// and expanded-symbol output side, both valid/ready.
interface rle_decoder_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output in_data, in_valid, out_ready,
                  input  in_ready, out_data, out_valid);
  modport slave  (input  in_data, in_valid, out_ready,
                  output in_ready, out_data, out_valid);
endinterface

// File: rtl/rle_decoder.sv
// Run-length decoder: expands (count, symbol) byte pairs into count copies of symbol.
// Optional macro RLE_ZERO_ERR_EN adds a sticky err output for zero-count pairs.
module rle_decoder #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  rle_decoder_if.slave  bus
`ifdef RLE_ZERO_ERR_EN
  ,
  output logic          err
`endif
);

  typedef enum logic [1:0] {IDLE, READ_SYM, EXPAND} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
  logic [DATA_W-1:0] r_sym,   w_sym_nxt;
  logic              w_in_ready;

  // in_ready depends on state only, so upstream never sees a combinational path
  // from out_ready.
  assign w_in_ready    = (r_state == IDLE) || (r_state == READ_SYM);
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == EXPAND);
  assign bus.out_data  = r_sym;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sym   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sym   <= w_sym_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sym_nxt   = r_sym;
    case (r_state)
      IDLE: begin
        if (bus.in_valid && w_in_ready) begin
          w_cnt_nxt   = bus.in_data[CNT_W-1:0];
          w_state_nxt = READ_SYM;
        end
      end
      READ_SYM: begin
        if (bus.in_valid && w_in_ready) begin
          w_sym_nxt   = bus.in_data;
          // A zero count drops the pair without producing output.
          w_state_nxt = (r_cnt == '0) ? IDLE : EXPAND;
        end
      end
      EXPAND: begin
        if (bus.out_ready) begin
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef RLE_ZERO_ERR_EN
  logic r_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_err <= 1'b0;
    else if (r_state == READ_SYM && bus.in_valid && r_cnt == '0)
      r_err <= 1'b1;
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_rle_decoder.sv
// Directed scoreboard bench for rle_decoder: expected symbols are queued as pairs
// are sent and popped by a monitor on every output transfer.
module tb_rle_decoder;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rdy = 1'b1;
  logic tog = 1'b0;
  logic tog_en = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   xfer_cnt = 0;
  int   xfer_cyc[$];
  logic [7:0] q[$];
  logic stall_prev = 1'b0;
  logic [7:0] stall_d = '0;

  rle_decoder_if #(.DATA_W(8)) bus ();
`ifdef RLE_ZERO_ERR_EN
  logic err;
`endif

  rle_decoder #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
`ifdef RLE_ZERO_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) tog <= ~tog;
  assign bus.out_ready = tog_en ? tog : rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: transfer happens on the next rising edge when valid&ready here.
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_data", 32'(bus.out_data), 32'(stall_d));
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_d    = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) chk("extra_output", 32'(bus.out_data), 32'hFFFF_FFFF);
        else chk("out_data", 32'(bus.out_data), 32'(q.pop_front()));
        xfer_cyc.push_back(cyc);
        xfer_cnt++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, output int acc);
    int n;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    acc = -1;
    for (n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    if (n == 1000) chk("in_ready_timeout", 32'd0, 32'd1);
    else acc = cyc;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] c, input logic [7:0] s, output int acc);
    int a0;
    send_byte(c, a0);
    send_byte(s, acc);
    for (int i = 0; i < c; i++) q.push_back(s);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    for (n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (q.size() == 0 && !bus.out_valid) break;
    end
    chk(tag, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int acc, base, bidx;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;

    // 1. reset
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
`ifdef RLE_ZERO_ERR_EN
    chk("rst_err", 32'(err), 32'd0);
`endif
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // 2. (3,0xA5) at full rate
    base = xfer_cnt; bidx = xfer_cyc.size();
    send_pair(8'd3, 8'hA5, acc);
    wait_drain("t2_drain");
    chk("t2_count", 32'(xfer_cnt - base), 32'd3);
    chk("t2_latency", 32'(xfer_cyc[bidx]), 32'(acc + 1));
    chk("t2_consec1", 32'(xfer_cyc[bidx+1] - xfer_cyc[bidx]), 32'd1);
    chk("t2_consec2", 32'(xfer_cyc[bidx+2] - xfer_cyc[bidx+1]), 32'd1);
    chk("t2_in_ready", 32'(bus.in_ready), 32'd1);

    // 3. (4,0x3C) with out_ready toggling
    @(posedge clk); #1;
    tog_en = 1'b1;
    base = xfer_cnt;
    send_pair(8'd4, 8'h3C, acc);
    wait_drain("t3_drain");
    repeat (3) @(negedge clk);
    chk("t3_count", 32'(xfer_cnt - base), 32'd4);
    @(posedge clk); #1;
    tog_en = 1'b0;

    // 4. zero-count pair dropped
    base = xfer_cnt;
    send_pair(8'd0, 8'h11, acc);
    send_pair(8'd2, 8'h22, acc);
    wait_drain("t4_drain");
    repeat (3) @(negedge clk);
    chk("t4_count", 32'(xfer_cnt - base), 32'd2);
`ifdef RLE_ZERO_ERR_EN
    chk("t4_err", 32'(err), 32'd1);
`endif
    @(posedge clk); #1;

    // 5. max count, then back-to-back single copies
    base = xfer_cnt;
    send_pair(8'd255, 8'hFF, acc);
    wait_drain("t5_drain_max");
    chk("t5_count_max", 32'(xfer_cnt - base), 32'd255);
    @(posedge clk); #1;
    base = xfer_cnt; bidx = xfer_cyc.size();
    send_pair(8'd1, 8'h01, acc);
    send_pair(8'd1, 8'h02, acc);
    wait_drain("t5_drain_b2b");
    chk("t5_count_b2b", 32'(xfer_cnt - base), 32'd2);
    chk("t5_pair_period", 32'(xfer_cyc[bidx+1] - xfer_cyc[bidx]), 32'd3);
    @(posedge clk); #1;

    // 6. reset mid-run, then a clean pair
    base = xfer_cnt;
    send_pair(8'd5, 8'h77, acc);
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (xfer_cnt >= base + 2) break;
    end
    reset_n = 1'b0;
    #1;
    chk("t6_abort_valid", 32'(bus.out_valid), 32'd0);
    q.delete();
    repeat (3) @(posedge clk);
    chk("t6_abort_count", 32'(xfer_cnt - base), 32'd2);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    base = xfer_cnt;
    send_pair(8'd1, 8'h88, acc);
    wait_drain("t6_drain");
    repeat (3) @(negedge clk);
    chk("t6_count", 32'(xfer_cnt - base), 32'd1);
`ifdef RLE_ZERO_ERR_EN
    chk("t6_err_cleared", 32'(err), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
